// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the gate-model BIST controller.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_t;

  // x^14+x^5+x^3+x+1: taps at bits 13, 4, 2, 0
  localparam logic [13:0] LfsrTaps = 14'h2015;

  // Signature feedback taps at bits 15, 14, 12, 3
  localparam logic [15:0] MisrTaps = 16'hD008;

  localparam int unsigned MisrW = 16;

endpackage

// File: rtl/bist_misr.sv
// 16-bit multiple-input signature register; parallel input is zero-extended.
module bist_misr
  import gate_bist_pkg::*;
#(
  parameter int unsigned OUT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [OUT_W-1:0] din,
  output logic [MisrW-1:0] sig,
  output logic [MisrW-1:0] sig_next
);

  logic [MisrW-1:0] sig_q;
  logic             fb;

  // Next signature value, exposed so the caller can judge the final capture early
  always_comb begin
    fb       = ^(sig_q & MisrTaps);
    sig_next = {sig_q[MisrW-2:0], fb} ^ MisrW'(din);
  end

  // Signature register: clear wins over capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else if (clr) begin
      sig_q <= '0;
    end else if (en) begin
      sig_q <= sig_next;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/gate_model_bist.sv
// BIST controller: LFSR stimulus, MISR compaction and a run/compare FSM.
module gate_model_bist
  import gate_bist_pkg::*;
#(
  parameter int unsigned     IN_W     = 14,
  parameter int unsigned     OUT_W    = 10,
  parameter int unsigned     PATTERNS = 1024,
  parameter int unsigned     HOLD     = 1,
  parameter logic [IN_W-1:0] SEED     = 14'h0001,
  parameter logic [15:0]     GOLDEN   = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      signature
);

  localparam int unsigned PcntW = $clog2(PATTERNS + 1);
  localparam int unsigned HcntW = $clog2(HOLD + 1);
  // An all-zero seed would lock the LFSR up
  localparam logic [IN_W-1:0] SeedEff  = (SEED == '0) ? IN_W'(1) : SEED;
  localparam logic [PcntW-1:0] PatLast = PcntW'(PATTERNS - 1);
  localparam logic [HcntW-1:0] HoldLast = HcntW'(HOLD - 1);

  state_t           state_q, state_d;
  logic [IN_W-1:0]  lfsr_q, lfsr_d;
  logic [PcntW-1:0] pcnt_q, pcnt_d;
  logic [HcntW-1:0] hcnt_q, hcnt_d;
  logic             pass_q, pass_d;
  logic             misr_clr, misr_en;
  logic [15:0]      misr_next;
  logic             lfsr_fb;

  bist_misr #(
    .OUT_W (OUT_W)
  ) u_misr (
    .clk      (clk),
    .rst      (rst),
    .clr      (misr_clr),
    .en       (misr_en),
    .din      (dut_out),
    .sig      (signature),
    .sig_next (misr_next)
  );

  // Next-state logic: start arms a run, each capture steps LFSR/MISR/pattern count
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    pcnt_d   = pcnt_q;
    hcnt_d   = hcnt_q;
    pass_d   = pass_q;
    misr_clr = 1'b0;
    misr_en  = 1'b0;
    lfsr_fb  = ^(lfsr_q & LfsrTaps);
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StRun;
          lfsr_d   = SeedEff;
          pcnt_d   = '0;
          hcnt_d   = '0;
          pass_d   = 1'b0;
          misr_clr = 1'b1;
        end
      end
      StRun: begin
        if (hcnt_q == HoldLast) begin
          misr_en = 1'b1;
          lfsr_d  = {lfsr_q[IN_W-2:0], lfsr_fb};
          pcnt_d  = pcnt_q + PcntW'(1);
          hcnt_d  = '0;
          if (pcnt_q == PatLast) begin
            state_d = StDone;
            pass_d  = (misr_next == GOLDEN);
          end
        end else begin
          hcnt_d = hcnt_q + HcntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset restores the seed so dut_in is defined out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      lfsr_q  <= SeedEff;
      pcnt_q  <= '0;
      hcnt_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      pcnt_q  <= pcnt_d;
      hcnt_q  <= hcnt_d;
      pass_q  <= pass_d;
    end
  end

  assign dut_in = lfsr_q;
  assign busy   = (state_q == StRun);
  assign done   = (state_q == StDone);
  assign pass   = pass_q;

endmodule

// File: tb/tb_gate_model_bist.sv
module tb_gate_model_bist;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_ab = 1'b0;
  logic start_c = 1'b0;
  logic start_de = 1'b0;

  logic [13:0] a_in, b_in, c_in, d_in, e_in;
  logic [15:0] a_sig, b_sig, c_sig, d_sig, e_sig;
  logic a_busy, a_done, a_pass, b_busy, b_done, b_pass, c_busy, c_done, c_pass;
  logic d_busy, d_done, d_pass, e_busy, e_done, e_pass;
  logic [9:0] zero_out = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gate_model_bist #(.PATTERNS(4), .HOLD(1), .SEED(14'h0001), .GOLDEN(16'h0004)) u_a (
    .clk(clk), .rst(rst), .start(start_ab), .dut_in(a_in), .dut_out(a_in[9:0]),
    .busy(a_busy), .done(a_done), .pass(a_pass), .signature(a_sig));

  gate_model_bist #(.PATTERNS(4), .HOLD(1), .SEED(14'h0001), .GOLDEN(16'h0005)) u_b (
    .clk(clk), .rst(rst), .start(start_ab), .dut_in(b_in), .dut_out(b_in[9:0]),
    .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_sig));

  gate_model_bist #(.PATTERNS(4), .HOLD(3), .SEED(14'h0001), .GOLDEN(16'h0004)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .dut_in(c_in), .dut_out(c_in[9:0]),
    .busy(c_busy), .done(c_done), .pass(c_pass), .signature(c_sig));

  gate_model_bist #(.PATTERNS(16383), .HOLD(1), .SEED(14'h0001), .GOLDEN(16'h0000)) u_d (
    .clk(clk), .rst(rst), .start(start_de), .dut_in(d_in), .dut_out(zero_out),
    .busy(d_busy), .done(d_done), .pass(d_pass), .signature(d_sig));

  gate_model_bist #(.PATTERNS(16383), .HOLD(1), .SEED(14'h0001), .GOLDEN(16'h1234)) u_e (
    .clk(clk), .rst(rst), .start(start_de), .dut_in(e_in), .dut_out(zero_out),
    .busy(e_busy), .done(e_done), .pass(e_pass), .signature(e_sig));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [13:0] din;
    logic [15:0] sig;
    logic        busy;
    logic        done;
    logic        pass_a;
    logic        pass_b;
  } vec_t;

  vec_t tbl[5];
  logic [13:0] cvec[5];
  logic [15:0] csig[5];
  int cyc;

  initial begin
    // Hand-computed: seed 1, dut_out = dut_in[9:0]
    tbl[0] = '{din: 14'h0001, sig: 16'h0000, busy: 1'b1, done: 1'b0, pass_a: 1'b0, pass_b: 1'b0};
    tbl[1] = '{din: 14'h0003, sig: 16'h0001, busy: 1'b1, done: 1'b0, pass_a: 1'b0, pass_b: 1'b0};
    tbl[2] = '{din: 14'h0007, sig: 16'h0001, busy: 1'b1, done: 1'b0, pass_a: 1'b0, pass_b: 1'b0};
    tbl[3] = '{din: 14'h000E, sig: 16'h0005, busy: 1'b1, done: 1'b0, pass_a: 1'b0, pass_b: 1'b0};
    tbl[4] = '{din: 14'h001D, sig: 16'h0004, busy: 1'b0, done: 1'b1, pass_a: 1'b1, pass_b: 1'b0};
    for (int i = 0; i < 5; i++) begin
      cvec[i] = tbl[i].din;
      csig[i] = tbl[i].sig;
    end

    // Reset values
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("rst_din", a_in, 14'h0001);
    chk("rst_sig", a_sig, 16'h0000);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_pass", a_pass, 0);

    // Basic run, HOLD=1
    start_ab = 1'b1;
    tick();
    start_ab = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("run_din[%0d]", i), a_in, tbl[i].din);
      chk($sformatf("run_sig[%0d]", i), a_sig, tbl[i].sig);
      chk($sformatf("run_busy[%0d]", i), a_busy, tbl[i].busy);
      chk($sformatf("run_done[%0d]", i), a_done, tbl[i].done);
      chk($sformatf("run_pass_a[%0d]", i), a_pass, tbl[i].pass_a);
      chk($sformatf("run_pass_b[%0d]", i), b_pass, tbl[i].pass_b);
      chk($sformatf("run_sig_b[%0d]", i), b_sig, tbl[i].sig);
      if (i < 4) tick();
    end
    tick();
    chk("done_hold_done", a_done, 1);
    chk("done_hold_din", a_in, 14'h001D);
    chk("done_hold_sig", a_sig, 16'h0004);
    chk("done_hold_pass", a_pass, 1);

    // HOLD=3: each vector held 3 cycles, done at t0+12
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      chk($sformatf("hold_din[%0d]", k), c_in, cvec[k / 3]);
      chk($sformatf("hold_sig[%0d]", k), c_sig, csig[k / 3]);
      chk($sformatf("hold_busy[%0d]", k), c_busy, (k < 12));
      chk($sformatf("hold_done[%0d]", k), c_done, (k == 12));
      if (k < 12) tick();
    end
    chk("hold_pass", c_pass, 1);

    // start pulse during RUN is ignored
    start_ab = 1'b1;
    tick();
    start_ab = 1'b0;
    tick();
    start_ab = 1'b1;
    tick();
    start_ab = 1'b0;
    tick();
    chk("ign_busy3", a_busy, 1);
    chk("ign_done3", a_done, 0);
    tick();
    chk("ign_done4", a_done, 1);
    chk("ign_sig4", a_sig, 16'h0004);
    chk("ign_pass4", a_pass, 1);

    // start held across the DONE edge restarts immediately
    start_ab = 1'b1;
    repeat (5) tick();
    chk("held_done4", a_done, 1);
    tick();
    chk("held_busy5", a_busy, 1);
    chk("held_done5", a_done, 0);
    chk("held_din5", a_in, 14'h0001);
    chk("held_sig5", a_sig, 16'h0000);
    chk("held_pass5", a_pass, 0);
    start_ab = 1'b0;
    repeat (4) tick();
    chk("held_done9", a_done, 1);
    chk("held_sig9", a_sig, 16'h0004);

    // Asynchronous reset mid-run, then a clean rerun
    start_ab = 1'b1;
    tick();
    start_ab = 1'b0;
    tick();
    #3 rst = 1'b1;
    #1;
    chk("mrst_din", a_in, 14'h0001);
    chk("mrst_sig", a_sig, 16'h0000);
    chk("mrst_busy", a_busy, 0);
    chk("mrst_done", a_done, 0);
    chk("mrst_pass", a_pass, 0);
    chk("mrst_sig_b", b_sig, 16'h0000);
    rst = 1'b0;
    tick();
    start_ab = 1'b1;
    tick();
    start_ab = 1'b0;
    repeat (4) tick();
    chk("rerun_done", a_done, 1);
    chk("rerun_sig", a_sig, 16'h0004);
    chk("rerun_pass", a_pass, 1);

    // Full-period run with a stuck-at-0 netlist
    start_de = 1'b1;
    tick();
    start_de = 1'b0;
    cyc = 0;
    while (!d_done && cyc < 20000) begin
      chk("lfsr_nonzero", (d_in != 14'h0000), 1);
      tick();
      cyc++;
    end
    chk("full_cycles", cyc, 16383);
    chk("full_din_seed", d_in, 14'h0001);
    chk("full_sig_d", d_sig, 16'h0000);
    chk("full_pass_d", d_pass, 1);
    chk("full_sig_e", e_sig, 16'h0000);
    chk("full_pass_e", e_pass, 0);
    chk("full_done_e", e_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gate_model_bist.md
# gate_model_bist

Built-in self-test controller for the 14-input / 10-output combinational gate-model netlists in the simulator gate library. It sits opposite such a netlist and closes the loop around it:
- an LFSR drives pseudo-random vectors onto the netlist inputs;
- a MISR compacts the netlist outputs into a 16-bit signature;
- an FSM sequences one run and compares the signature against a golden value.

## Interface
Parameters:
- IN_W, 14, netlist input width (LFSR width; tap set below is fixed for 14).
- OUT_W, 10, netlist output width (≤ 16).
- PATTERNS, 1024, vectors applied per run (≥ 1).
- HOLD, 1, clock cycles each vector is held before its response is sampled (≥ 1).
- SEED, 14'h0001, LFSR start value (0 is replaced by 14'h0001).
- GOLDEN, 16'h0000, expected final signature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  begin a run; sampled in IDLE and DONE only.
- dut_in  out  IN_W  vector driven to the netlist; this is the LFSR register directly.
- dut_out  in  OUT_W  netlist response.
- busy  out  1  high while in RUN.
- done  out  1  high in DONE; stays high until the next start or rst.
- pass  out  1  valid while done; 1 iff signature == GOLDEN.
- signature  out  16  MISR contents; final value once done.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE→RUN on start.
  - RUN→DONE on the capture that makes the pattern count equal PATTERNS.
  - DONE→RUN on start.
  - There is no other transition.
- Entering RUN: the LFSR loads SEED, the MISR clears to 0, the pattern counter and hold counter clear to 0.
- LFSR step (Fibonacci): fb = q[13]^q[4]^q[2]^q[0]; q_next = {q[12:0], fb}. This is polynomial x^14+x^5+x^3+x+1, maximal length 16383.
- MISR capture: fb = s[15]^s[14]^s[12]^s[3]; s_next = {s[14:0], fb} ^ zero-extend(dut_out).
- Capture occurs in RUN when the hold counter equals HOLD-1. In the same cycle:
  - the MISR updates;
  - the LFSR steps;
  - the pattern counter increments;
  - the hold counter wraps to 0.
- Otherwise in RUN, the hold counter increments and the LFSR and MISR hold.
- pass is registered on the final capture as (s_next == GOLDEN). It is cleared on rst and on start.
- start while busy is ignored.
- In IDLE and DONE, the LFSR and MISR hold their values.
- Counter widths are $clog2(PATTERNS+1) and $clog2(HOLD+1). No wrap-around is possible within one run.

## Timing
Reset values:
- state IDLE, dut_in = SEED (or 1 if SEED = 0);
- signature 0;
- busy 0, done 0, pass 0.

Run timing, with start sampled high at edge t0:
- At t0: busy = 1, dut_in = SEED.
- Vector k (k = 0..PATTERNS-1) is driven from edge t0+k·HOLD and sampled at edge t0+(k+1)·HOLD.
- dut_out must settle within HOLD cycles.
- At edge t0+PATTERNS·HOLD: busy = 0, done = 1, pass and signature final.
- Total run length is PATTERNS·HOLD cycles.

Boundary conditions:
- rst at any point returns all state to the reset values at once, including mid-run; no partial signature remains.
- start held high across the DONE edge restarts at the next edge: done falls and busy rises in the same cycle.

## Structure
- Package gate_bist_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - LFSR tap mask 14'h2015;
  - MISR tap mask 16'hD008;
  - MISR width constant 16.
- One sub-module, bist_misr: a 16-bit MISR with clr, en and a parallel input zero-extended from OUT_W.
- The LFSR and FSM stay in the top level.

## Test plan
- Reset: assert rst mid-cycle → outputs read dut_in=14'h0001, signature 0, busy 0, done 0, pass 0 without waiting for a clock edge.
- PATTERNS=4, HOLD=1, SEED=1, GOLDEN=16'h0004, dut_out = dut_in[9:0] → dut_in sequence 0x0001, 0x0003, 0x0007, 0x000E; signature sequence 0x0001, 0x0001, 0x0005, 0x0004; done at t0+4 with pass=1.
- Same run with GOLDEN=16'h0005 → signature 0x0004, pass=0.
- HOLD=3, PATTERNS=4 → each vector stable for 3 cycles; done at t0+12; signature 0x0004.
- Pulse start at t0+2 during RUN → ignored, done still at t0+4. Then pulse rst at t0+2 on a second run → everything at reset values; a new start yields the same signature 0x0004.
- PATTERNS=16383, stuck DUT (dut_out=0) → signature 0 and pass iff GOLDEN=0. Also check that dut_in never equals 0 and returns to SEED after 16383 steps.
